cic_comp_fir: RTL and testbench

- Decimating compensation FIR placed directly downstream of the CIC decimator.
- Flattens the CIC passband droop and decimates further by DECIMATION.
- Consumes CIC output words as single-cycle strobes in the system clock domain. A synchroniser upstream converts the CIC output-clock edge into the i_valid pulse.
- Uses one time-multiplexed multiplier: one tap per cycle.

---
 rtl/cic_comp_fir_pkg.sv | 30 +++
 rtl/cic_comp_fir_round_sat.sv | 41 ++++
 rtl/cic_comp_fir.sv | 175 +++++++++++++++++
 tb/tb_cic_comp_fir.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_fir_pkg.sv
// cic_comp_fir_pkg: shared FSM encoding, default taps and
// a constant clog2 for the CIC compensation FIR.
package cic_comp_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2
    } fir_state_t;

    localparam int DEF_N_TAPS     = 7;
    localparam int DEF_COEF_WIDTH = 12;

    // Tap 0 in the LSBs: {-16,0,144,256,144,0,-16}.
    // Taps sum to 512, i.e. unity DC gain at 9 fraction bits.
    localparam logic [DEF_N_TAPS*DEF_COEF_WIDTH-1:0]
        DEF_COEFS = {
            12'hff0, 12'h000, 12'h090, 12'h100,
            12'h090, 12'h000, 12'hff0
        };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// round_sat: round half toward +inf, drop FRAC bits, saturate.
// Ports: i_data (IN_WIDTH signed) -> o_data (OUT_WIDTH signed).
module round_sat #(
    parameter int IN_WIDTH  = 31,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC      = 9
) (
    input  logic signed [IN_WIDTH-1:0]  i_data,
    output logic signed [OUT_WIDTH-1:0] o_data
);

    // One guard bit so the rounding bias cannot wrap.
    localparam int EW = IN_WIDTH + 1;

    localparam logic signed [EW-1:0] HALF =
        EW'(1) << (FRAC - 1);
    localparam logic signed [EW-1:0] MAXV = {
        {(EW-OUT_WIDTH+1){1'b0}},
        {(OUT_WIDTH-1){1'b1}}
    };
    localparam logic signed [EW-1:0] MINV = {
        {(EW-OUT_WIDTH+1){1'b1}},
        {(OUT_WIDTH-1){1'b0}}
    };

    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] shifted;

    assign biased  = {i_data[IN_WIDTH-1], i_data} + HALF;
    assign shifted = biased >>> FRAC;

    always_comb begin
        if (shifted > MAXV)
            o_data = MAXV[OUT_WIDTH-1:0];
        else if (shifted < MINV)
            o_data = MINV[OUT_WIDTH-1:0];
        else
            o_data = shifted[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimating droop-compensation FIR after the CIC,
// one shared multiplier, one tap per cycle.
// Ports: i_clk, i_rst (async, low), i_en (clock enable),
//   i_valid/i_data (input strobe + sample),
//   o_valid/o_data (output strobe + held sample),
//   o_busy (MAC/ROUND in progress), o_overrun (sticky drop).
module cic_comp_fir
    import cic_comp_fir_pkg::*;
#(
    parameter int I_WIDTH    = 16,
    parameter int O_WIDTH    = 16,
    parameter int COEF_WIDTH = 12,
    parameter int COEF_FRAC  = 9,
    parameter int N_TAPS     = 7,
    parameter int DECIMATION = 2,
    parameter logic [N_TAPS*COEF_WIDTH-1:0]
        COEFS = DEF_COEFS
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  logic signed [I_WIDTH-1:0] i_data,
    output logic                      o_valid,
    output logic signed [O_WIDTH-1:0] o_data,
    output logic                      o_busy,
    output logic                      o_overrun
);

    localparam int DEPTH = N_TAPS + DECIMATION;
    localparam int AW    = clog2(DEPTH);
    localparam int KW    = clog2(N_TAPS);
    localparam int PW    = clog2(DECIMATION + 1);
    localparam int PRW   = I_WIDTH + COEF_WIDTH;
    localparam int ACC_WIDTH = PRW + clog2(N_TAPS);

    fir_state_t state_q;
    fir_state_t state_d;

    logic signed [I_WIDTH-1:0] smp_buf [DEPTH];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] trig_ptr_q;
    logic [AW-1:0] newest_q;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tap_aw;
    logic [PW-1:0] phase_q;
    logic [KW-1:0] tap_q;
    logic          trig_q;

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [I_WIDTH-1:0]    x_rd;
    logic signed [COEF_WIDTH-1:0] coef_k;
    logic signed [PRW-1:0]        prod;
    logic signed [O_WIDTH-1:0]    rnd_data;

    logic accept;
    logic trig;
    logic start;
    logic mac_go;
    logic rnd_go;
    logic busy;

    assign accept = i_en & i_valid;
    assign trig   = accept &
                    (phase_q == PW'(DECIMATION - 1));

    // Sample store: written on every accepted strobe,
    // independent of the MAC sequence.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                smp_buf[i] <= '0;
            wr_ptr_q <= '0;
            phase_q  <= '0;
        end else if (accept) begin
            smp_buf[wr_ptr_q] <= i_data;
            wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ?
                        '0 : wr_ptr_q + AW'(1);
            phase_q  <= trig ? '0 : phase_q + PW'(1);
        end
    end

    // Trigger is registered with its address; IDLE
    // picks it up on the following cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            trig_q     <= 1'b0;
            trig_ptr_q <= '0;
        end else if (i_en) begin
            trig_q <= trig;
            if (trig) trig_ptr_q <= wr_ptr_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else if (i_en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (trig_q) state_d = ST_MAC;
            ST_MAC:   if (tap_q == KW'(N_TAPS - 1))
                          state_d = ST_ROUND;
            ST_ROUND: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start  = 1'b0;
        mac_go = 1'b0;
        rnd_go = 1'b0;
        busy   = 1'b0;
        unique case (state_q)
            ST_IDLE:  start = trig_q;
            ST_MAC:   begin busy = 1'b1; mac_go = 1'b1; end
            ST_ROUND: begin busy = 1'b1; rnd_go = 1'b1; end
            default:  ;
        endcase
    end

    assign o_busy = busy;

    // x[newest - k] modulo DEPTH.
    assign tap_aw = AW'(tap_q);
    assign rd_ptr = (newest_q >= tap_aw) ?
                    newest_q - tap_aw :
                    newest_q + AW'(DEPTH) - tap_aw;
    assign x_rd   = smp_buf[rd_ptr];
    assign coef_k = COEFS[int'(tap_q)*COEF_WIDTH +: COEF_WIDTH];
    assign prod   = x_rd * coef_k;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            newest_q <= '0;
            tap_q    <= '0;
            acc_q    <= '0;
        end else if (i_en) begin
            if (start) begin
                newest_q <= trig_ptr_q;
                tap_q    <= '0;
                acc_q    <= '0;
            end else if (mac_go) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
                tap_q <= tap_q + KW'(1);
            end
        end
    end

    round_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (O_WIDTH),
        .FRAC      (COEF_FRAC)
    ) u_round_sat (
        .i_data (acc_q),
        .o_data (rnd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= rnd_go & i_en;
            if (i_en && rnd_go) o_data <= rnd_data;
            if (i_en && trig_q && state_q != ST_IDLE)
                o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: scoreboard bench for cic_comp_fir with three
// instances (DECIMATION=1, DECIMATION=2, O_WIDTH=12).
module tb_cic_comp_fir;

    typedef struct {
        int     val;
        longint t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    logic rst1, en1, vld1, ov1, bs1, or1;
    logic signed [15:0] dat1, od1;
    logic rst2, en2, vld2, ov2, bs2, or2;
    logic signed [15:0] dat2, od2;
    logic rst3, en3, vld3, ov3, bs3, or3;
    logic signed [15:0] dat3;
    logic signed [11:0] od3;

    cic_comp_fir #(.DECIMATION(1)) u_d1 (
        .i_clk(clk), .i_rst(rst1), .i_en(en1),
        .i_valid(vld1), .i_data(dat1),
        .o_valid(ov1), .o_data(od1),
        .o_busy(bs1), .o_overrun(or1)
    );

    cic_comp_fir #(.DECIMATION(2)) u_d2 (
        .i_clk(clk), .i_rst(rst2), .i_en(en2),
        .i_valid(vld2), .i_data(dat2),
        .o_valid(ov2), .o_data(od2),
        .o_busy(bs2), .o_overrun(or2)
    );

    cic_comp_fir #(.O_WIDTH(12), .DECIMATION(1)) u_o12 (
        .i_clk(clk), .i_rst(rst3), .i_en(en3),
        .i_valid(vld3), .i_data(dat3),
        .o_valid(ov3), .o_data(od3),
        .o_busy(bs3), .o_overrun(or3)
    );

    task automatic chk(input string name,
                       input longint got,
                       input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, got, exp);
        end
    endtask

    // Drive one strobe; push the expected word and the
    // edge time at which o_valid must be seen.
    task automatic send(input int id, input int x,
                        input bit ex, input int ev,
                        input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        case (id)
            1: begin vld1 = 1'b1; dat1 = 16'(x); end
            2: begin vld2 = 1'b1; dat2 = 16'(x); end
            default: begin vld3 = 1'b1; dat3 = 16'(x); end
        endcase
        @(posedge clk);
        e.val = ev;
        e.t   = longint'($time) + longint'(lat) * 10;
        if (ex) begin
            case (id)
                1: q1.push_back(e);
                2: q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
        #1;
        case (id)
            1: vld1 = 1'b0;
            2: vld2 = 1'b0;
            default: vld3 = 1'b0;
        endcase
    endtask

    task automatic score(input int id, input int got,
                         input logic busy);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (id)
            1: if (q1.size() > 0) begin
                   e = q1.pop_front(); have = 1'b1;
               end
            2: if (q2.size() > 0) begin
                   e = q2.pop_front(); have = 1'b1;
               end
            default: if (q3.size() > 0) begin
                   e = q3.pop_front(); have = 1'b1;
               end
        endcase
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL dut%0d_unexpected_valid: got %0d, expected no output",
                     id, got);
        end else begin
            chk($sformatf("dut%0d_data", id), got, e.val);
            chk($sformatf("dut%0d_valid_time", id),
                longint'($time) - 5, e.t);
        end
        chk($sformatf("dut%0d_busy_at_valid", id), busy, 0);
    endtask

    always @(negedge clk) if (ov1) score(1, int'(od1), bs1);
    always @(negedge clk) if (ov2) score(2, int'(od2), bs2);
    always @(negedge clk) if (ov3) score(3, int'(od3), bs3);

    int imp[8] = '{-16, 0, 144, 256, 144, 0, -16, 0};
    int d2e[6] = '{-31, 750, 1031, 1000, 1000, 1000};

    int in3[35] = '{
        3000, 3000, 3000, 3000, 3000, 3000, 3000,
        -3000, -3000, -3000, -3000, -3000, -3000, -3000,
        0, 0, 0, 0, 0, 0, 0,
        1, 0, 0, 0, 0, 0, 0,
        -1, 0, 0, 0, 0, 0, 0
    };
    int out3[35] = '{
        -94, -94, 750, 2047, 2047, 2047, 2047,
        2047, 2047, 1500, -1500, -2048, -2048, -2048,
        -2048, -2048, -2048, -750, 94, 94, 0,
        0, 0, 0, 1, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0
    };

    initial begin
        rst1 = 0; en1 = 1; vld1 = 0; dat1 = '0;
        rst2 = 0; en2 = 1; vld2 = 0; dat2 = '0;
        rst3 = 0; en3 = 1; vld3 = 0; dat3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("d1_rst_valid", ov1, 0);
        chk("d1_rst_data", od1, 0);
        chk("d1_rst_busy", bs1, 0);
        chk("d1_rst_overrun", or1, 0);
        chk("d2_rst_valid", ov2, 0);
        chk("d2_rst_data", od2, 0);
        chk("d2_rst_busy", bs2, 0);
        chk("o12_rst_data", od3, 0);
        rst1 = 1; rst2 = 1; rst3 = 1;

        fork
            begin
                // Impulse response, 10-cycle spacing.
                send(1, 512, 1, imp[0], 9);
                repeat (2) @(posedge clk);
                #1 chk("d1_busy_mac", bs1, 1);
                repeat (6) @(posedge clk);
                for (int k = 1; k < 8; k++) begin
                    send(1, 0, 1, imp[k], 9);
                    repeat (8) @(posedge clk);
                end
                // Same impulse, enable dropped mid-MAC.
                send(1, 512, 1, imp[0], 14);
                repeat (2) @(posedge clk);
                #1 en1 = 0;
                repeat (5) @(posedge clk);
                #1 en1 = 1;
                repeat (6) @(posedge clk);
                for (int k = 1; k < 8; k++) begin
                    send(1, 0, 1, imp[k], 9);
                    repeat (8) @(posedge clk);
                end
                // Overrun: second trigger 3 cycles later.
                send(1, 512, 1, -16, 9);
                #1 chk("d1_overrun_before", or1, 0);
                @(posedge clk);
                send(1, 256, 0, 0, 0);
                @(posedge clk);
                #1 chk("d1_overrun_set", or1, 1);
                repeat (6) @(posedge clk);
                send(1, 0, 1, 144, 9);
                repeat (12) @(posedge clk);
                #1 chk("d1_overrun_sticky", or1, 1);
                // Reset in the third MAC cycle.
                send(1, 300, 0, 0, 0);
                repeat (3) @(posedge clk);
                #1 rst1 = 0;
                #1;
                chk("d1_abort_data", od1, 0);
                chk("d1_abort_valid", ov1, 0);
                chk("d1_abort_busy", bs1, 0);
                chk("d1_abort_overrun", or1, 0);
                repeat (3) @(posedge clk);
                #1 rst1 = 1;
                repeat (12) @(posedge clk);
                send(1, 512, 1, -16, 9);
                repeat (8) @(posedge clk);
                send(1, 0, 1, 0, 9);
                repeat (12) @(posedge clk);
                #1 chk("d1_overrun_after_rst", or1, 0);
            end
            begin
                // DC 1000, one output per two inputs.
                for (int i = 1; i <= 12; i++) begin
                    send(2, 1000, (i % 2) == 0,
                         d2e[(i / 2 + 5) % 6], 9);
                    repeat (8) @(posedge clk);
                end
                #1 chk("d2_no_overrun", or2, 0);
            end
            begin
                // Saturation and rounding, 9-cycle spacing.
                for (int i = 0; i < 35; i++) begin
                    send(3, in3[i], 1, out3[i], 9);
                    repeat (7) @(posedge clk);
                end
                #1 chk("o12_no_overrun", or3, 0);
            end
        join

        for (int i = 0; i < 100; i++) begin
            if (q1.size() + q2.size() + q3.size() == 0)
                break;
            @(posedge clk);
        end
        chk("pending_outputs",
            q1.size() + q2.size() + q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
